// File: rtl/instr_decoder.sv
// i281 instruction register and decode stage: captures the fetched word and
// holds the one-hot decoded opcode bus, immediate field and a retired count.
module instr_decoder #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   ir_load,
  input  logic                   flush,
  input  logic [15:0]            instr_in,
  output logic [26:0]            opcode_out,
  output logic [7:0]             imm_out,
  output logic [15:0]            ir_out,
  output logic                   decode_valid,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [26:0] NOOP_BUS = 27'h0000001;

  logic [3:0]             w_op;
  logic [1:0]             w_ry;
  logic [4:0]             w_sel;
  logic [22:0]            w_onehot;
  logic                   w_load;
  logic                   w_flush;

  logic [26:0]            r_opcode;
  logic [15:0]            r_ir;
  logic                   r_valid;
  logic [COUNT_WIDTH-1:0] r_count;

  assign w_op    = instr_in[15:12];
  assign w_ry    = instr_in[9:8];
  assign w_flush = run & flush;
  assign w_load  = run & ir_load & ~flush;

  // Sub-op families (INPUT, shift, branch) fold their selector into the index
  always_comb begin
    w_sel = 5'd0;
    case (w_op)
      4'h0: w_sel = 5'd0;
      4'h1: w_sel = 5'd1 + {3'b000, w_ry};
      4'h2: w_sel = 5'd5;
      4'h3: w_sel = 5'd6;
      4'h4: w_sel = 5'd7;
      4'h5: w_sel = 5'd8;
      4'h6: w_sel = 5'd9;
      4'h7: w_sel = 5'd10;
      4'h8: w_sel = 5'd11;
      4'h9: w_sel = 5'd12;
      4'hA: w_sel = 5'd13;
      4'hB: w_sel = 5'd14;
      4'hC: w_sel = 5'd15 + {4'b0000, instr_in[8]};
      4'hD: w_sel = 5'd17;
      4'hE: w_sel = 5'd18;
      4'hF: w_sel = 5'd19 + {3'b000, w_ry};
      default: w_sel = 5'd0;
    endcase
  end

  always_comb begin
    w_onehot = '0;
    w_onehot[w_sel] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_opcode <= NOOP_BUS;
      r_ir     <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_opcode <= NOOP_BUS;
      r_ir     <= '0;
      r_valid  <= 1'b0;
    end else if (w_load) begin
      r_opcode <= {instr_in[11:8], w_onehot};
      r_ir     <= instr_in;
      r_valid  <= 1'b1;
      if (r_count != '1) r_count <= r_count + 1'b1;
    end
  end

  assign opcode_out   = r_opcode;
  assign ir_out       = r_ir;
  assign imm_out      = r_ir[7:0];
  assign decode_valid = r_valid;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed-vector bench for instr_decoder with a 4-bit retired counter so
// saturation is reachable quickly.
module tb_instr_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        ir_load = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr_in = '0;
  logic [26:0] opcode_out;
  logic [7:0]  imm_out;
  logic [15:0] ir_out;
  logic        decode_valid;
  logic [3:0]  instr_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  instr_decoder #(.COUNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .run(run), .ir_load(ir_load),
    .flush(flush), .instr_in(instr_in), .opcode_out(opcode_out),
    .imm_out(imm_out), .ir_out(ir_out), .decode_valid(decode_valid),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycle(input logic r, input logic ld, input logic fl, input logic [15:0] w);
    @(negedge clock);
    run = r; ir_load = ld; flush = fl; instr_in = w;
    @(posedge clock);
    #1;
    ir_load = 1'b0; flush = 1'b0;
  endtask

  task automatic load(input logic [15:0] w);
    cycle(1'b1, 1'b1, 1'b0, w);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".opcode"}, 32'(opcode_out), 32'h0000001);
    check({tag, ".imm"},    32'(imm_out), 32'h0);
    check({tag, ".ir"},     32'(ir_out), 32'h0);
    check({tag, ".valid"},  32'(decode_valid), 32'h0);
    check({tag, ".count"},  32'(instr_count), 32'h0);
  endtask

  // Reference one-hot index from the opcode table
  function automatic int unsigned ref_idx(input logic [3:0] op, input logic [1:0] ry);
    int unsigned base[16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
    if (op == 4'h1 || op == 4'hF) return base[op] + ry;
    if (op == 4'hC) return base[op] + ry[0];
    return base[op];
  endfunction

  initial begin
    logic [26:0] exp_bus;
    logic [15:0] w;
    #1 reset = 1'b1;
    #2 check_reset_state("reset");
    @(negedge clock);
    reset = 1'b0;

    load(16'h4600);
    check("add.opcode", 32'(opcode_out), 32'h3000080);
    check("add.imm",    32'(imm_out), 32'h00);
    check("add.valid",  32'(decode_valid), 32'h1);
    check("add.count",  32'(instr_count), 32'h1);

    load(16'hF205);
    check("brg.opcode", 32'(opcode_out), 32'h1200000);
    check("brg.imm",    32'(imm_out), 32'h05);

    load(16'hC100);
    check("shiftr.opcode", 32'(opcode_out), 32'h0810000);
    check("shiftr.count",  32'(instr_count), 32'h3);

    cycle(1'b1, 1'b1, 1'b1, 16'h2400);
    check("flush.opcode", 32'(opcode_out), 32'h0000001);
    check("flush.ir",     32'(ir_out), 32'h0);
    check("flush.imm",    32'(imm_out), 32'h0);
    check("flush.valid",  32'(decode_valid), 32'h0);
    check("flush.count",  32'(instr_count), 32'h3);

    load(16'h7300);
    check("subi.opcode", 32'(opcode_out), 32'h1800400);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b1, i[0], 16'h1234);
    check("hold.opcode", 32'(opcode_out), 32'h1800400);
    check("hold.ir",     32'(ir_out), 32'h7300);
    check("hold.valid",  32'(decode_valid), 32'h1);
    check("hold.count",  32'(instr_count), 32'h4);

    for (int unsigned i = 0; i < 10; i++) load(16'h0000);
    check("sat.pre", 32'(instr_count), 32'hE);
    load(16'h0000);
    check("sat.first", 32'(instr_count), 32'hF);
    load(16'h0000);
    load(16'h0000);
    check("sat.stick", 32'(instr_count), 32'hF);

    for (int unsigned op = 0; op < 16; op++) begin
      for (int unsigned ry = 0; ry < 4; ry++) begin
        w = {op[3:0], ry[1:0] ^ op[1:0], ry[1:0], 8'hA5};
        load(w);
        exp_bus = '0;
        exp_bus[ref_idx(op[3:0], ry[1:0])] = 1'b1;
        exp_bus[26:23] = w[11:8];
        check($sformatf("sweep%0h_%0d.opcode", op, ry), 32'(opcode_out), 32'(exp_bus));
        check($sformatf("sweep%0h_%0d.ones", op, ry), $countones(opcode_out[22:0]), 32'd1);
        check($sformatf("sweep%0h_%0d.imm", op, ry), 32'(imm_out), 32'hA5);
      end
    end

    load(16'h9ABC);
    check("preasync.ir", 32'(ir_out), 32'h9ABC);
    #2 reset = 1'b1;
    #1 check_reset_state("async");
    @(negedge clock);
    reset = 1'b0;
    load(16'hE0FF);
    check("postrst.opcode", 32'(opcode_out), 32'h0040000);
    check("postrst.count",  32'(instr_count), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Registered instruction-register and decode stage for the i281 multicycle CPU. It captures the 16-bit instruction word fetched from code memory and produces the 27-bit decoded opcode bus that the control FSM consumes. The bus carries RX in [26:25], RY in [24:23] and a one-hot instruction select in [22:0]. The stage also provides the 8-bit immediate/address field, a decode-valid flag and a retired-instruction counter used by the debug display.

## Interface
- COUNT_WIDTH, 16, width of the retired-instruction counter.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  global run enable; when 0 all state holds.
- ir_load  in  1  capture strobe, driven from the FSM fetch-state control bit.
- flush  in  1  synchronous clear of the decoded instruction to NOOP.
- instr_in  in  16  instruction word from code memory.
- opcode_out  out  27  decoded bus: [26:25] RX, [24:23] RY, [22:0] one-hot.
- imm_out  out  8  instr[7:0], the immediate or address field.
- ir_out  out  16  raw captured instruction word.
- decode_valid  out  1  high once a decoded instruction is held.
- instr_count  out  COUNT_WIDTH  number of accepted loads, saturating.

## Operation
- Field split: op = instr[15:12], RX = instr[11:10], RY = instr[9:8], imm = instr[7:0].
- One-hot mapping, opcode_out bit index in parentheses:
  - 0000 → NOOP (0).
  - 0001 → INPUT family, selected by RY: 00 INPUTC (1), 01 INPUTCF (2), 10 INPUTD (3), 11 INPUTDF (4).
  - 0010 MOVE (5); 0011 LOADI/LOADP (6); 0100 ADD (7); 0101 ADDI (8); 0110 SUB (9); 0111 SUBI (10).
  - 1000 LOAD (11); 1001 LOADF (12); 1010 STORE (13); 1011 STOREF (14).
  - 1100 → shift, selected by instr[8]: 0 SHIFTL (15), 1 SHIFTR (16).
  - 1101 CMP (17); 1110 JUMP (18).
  - 1111 → branch, selected by RY: 00 BRE/BRZ (19), 01 BRNE/BRNZ (20), 10 BRG (21), 11 BRGE (22).
- RX and RY pass through unmodified in [26:23] for every opcode, including those that use RY as a sub-op selector.
- Exactly one bit of [22:0] is set at all times. All 16 opcodes are legal, so no illegal-instruction path exists.
- Accepted load: rising edge with run=1, ir_load=1, flush=0. On an accepted load:
  - ir_out, opcode_out and imm_out update from instr_in;
  - decode_valid is set to 1;
  - instr_count increments by 1, saturating at all-ones (no wrap).
- Flush: rising edge with run=1 and flush=1.
  - opcode_out ← 27'h0000001 (NOOP, RX=RY=0); ir_out ← 0; imm_out ← 0; decode_valid ← 0.
  - instr_count holds.
- Priority:
  - flush beats ir_load in the same cycle: result is a flush, no count increment.
  - run=0 overrides both: all registers hold.
- No load pending: all outputs hold their previous values indefinitely.

## Timing
- Reset values (asynchronous, immediate on reset assertion): opcode_out = 27'h0000001, imm_out = 0, ir_out = 0, decode_valid = 0, instr_count = 0.
- Latency: instr_in sampled at edge N with ir_load=1 appears on all outputs after edge N and is stable for the whole of cycle N+1. This matches the FSM's IF→ID transition, so ID sees the new opcode.
- Decode is computed combinationally from instr_in ahead of the register. All outputs are registered with no combinational path from inputs to outputs.
- Back-to-back ir_load in consecutive cycles: each edge captures a new word, and instr_count increments every cycle.
- Reset asserted mid-operation: outputs go to reset values immediately. The first load after reset deassertion needs one full clock edge.
- instr_in is not required to be stable except around edges where ir_load=1.

## Test plan
- Reset, then load 0x4600 (ADD RX=1 RY=2) → next cycle: opcode_out = 27'h3000080, imm_out = 0x00, decode_valid = 1, instr_count = 1.
- Load 0xF205 (BRG) → opcode_out = 27'h1200000, imm_out = 0x05. Then load 0xC100 (SHIFTR) → opcode_out[16] = 1, RY field = 01.
- Sweep all 64 combinations of op × RY with imm = 0xA5 → exactly one one-hot bit set and at the table index, RX/RY echoed, imm_out = 0xA5 every time.
- Assert flush and ir_load together with instr_in = 0x2400 → opcode_out = 27'h0000001, decode_valid = 0, instr_count unchanged.
- Hold run = 0 with ir_load pulsing → no output changes. Preload instr_count to all-ones minus 1 via loads (COUNT_WIDTH = 4), then do 3 more loads → count sticks at 4'hF.
- Assert reset asynchronously between clock edges after a load → all outputs return to reset values before the next edge.
